capture_sequencer: RTL and testbench
====================================

# capture_sequencer

Trigger and capture controller for the oscilloscope sample path. Runs on osc_clk, takes one 8-bit sample per ADC conversion, and writes samples into the circular sample RAM. It keeps a pre-trigger history, detects a level/slope trigger, and stops after the post-trigger segment. It then raises `capture_done` for the Pi readout side and re-arms on the Pi's `rearm` request.

## Interface
Parameters:
- `ADDR_W`, default 12: sample RAM address width. `DEPTH` = 2**ADDR_W.
- `PRE_DEPTH`, default 1024: samples kept before the trigger sample. Legal range 0..DEPTH-1.
- `AUTO_TIMEOUT`, default 65535: armed samples without a trigger before an auto trigger fires (16-bit). Used only under the macro below.

Ports:
- `osc_clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `sample_valid`  in  1  one-cycle pulse per completed conversion, synchronous to osc_clk.
- `sample`  in  8  conversion result, valid with `sample_valid`.
- `trig_level`  in  8  trigger threshold, unsigned. Quasi-static.
- `trig_slope`  in  1  0 = rising, 1 = falling.
- `rearm`  in  1  asynchronous level from Pi. Synchronized internally with 2 flops.
- `wr_en`  out  1  RAM write strobe.
- `wr_adr`  out  ADDR_W  RAM write address.
- `wr_data`  out  8  RAM write data.
- `capture_done`  out  1  record complete, RAM frozen.
- `trig_adr`  out  ADDR_W  address of the trigger sample.
- `start_adr`  out  ADDR_W  first address of the record, equal to (trig_adr - PRE_DEPTH) mod DEPTH.
- `auto_fired`  out  1  the current record was auto-triggered.
- `state_dbg`  out  2  current state encoding.

## Operation
- States: PRE_FILL=0, ARMED=1, POST=2, DONE=3.
- Reset enters PRE_FILL. If PRE_DEPTH=0, reset enters ARMED instead.
- Every `sample_valid` in PRE_FILL, ARMED or POST produces one write. The write address then increments, wrapping modulo DEPTH.
- `wr_adr` is never cleared except by reset, so successive records continue from where the previous one stopped.
- PRE_FILL: counts writes. Moves to ARMED on the edge that writes the PRE_DEPTH-th sample. The trigger is ignored in this state.
- `prev` holds the last written sample. It is invalidated on entry to PRE_FILL or ARMED, and no trigger can fire until `prev` is valid.
- Rising trigger: `prev` < trig_level and sample >= trig_level.
- Falling trigger: `prev` > trig_level and sample <= trig_level.
- ARMED: on a trigger sample, write it, latch trig_adr and start_adr from that sample's address, and go to POST. If DEPTH-PRE_DEPTH-1 = 0, go directly to DONE.
- POST: write exactly DEPTH-PRE_DEPTH-1 further samples, then go to DONE.
- DONE: no writes, `capture_done`=1. On a rising edge of the synchronized `rearm`:
  - clear `capture_done` and `auto_fired`;
  - clear the pre-fill count;
  - go to PRE_FILL (or ARMED if PRE_DEPTH=0).
- Rearm edges arriving in any state other than DONE are discarded and not remembered.
- Reset mid-operation: all state and outputs return to reset values immediately.

## Timing
- Reset values: `wr_en`=0, `wr_adr`=0, `wr_data`=0, `capture_done`=0, `trig_adr`=0, `start_adr`=0, `auto_fired`=0, `state_dbg`=0.
- All outputs are registered.
- `sample_valid` high in cycle N causes `wr_en` high for exactly cycle N+1, with that sample's `wr_adr` and `wr_data`.
- State transitions, `trig_adr` and `start_adr` update on the same edge as the corresponding write.
- `capture_done` rises together with the last POST `wr_en` pulse.
- `rearm` rising at the osc_clk input in cycle M causes `capture_done` to fall at edge M+3 (2 sync flops plus edge detect).
- A `sample_valid` in the same cycle as the DONE-exit edge is not written. The first write follows the next pulse.

## Configuration
- `CAPTURE_AUTO_TRIG_EN` defined: in ARMED, a 16-bit counter counts armed writes that are not triggers.
  - When the count reaches AUTO_TIMEOUT, the next armed sample is treated as the trigger and `auto_fired` is set.
  - The counter clears on entry to ARMED.
- `CAPTURE_AUTO_TRIG_EN` undefined: the counter is absent, `auto_fired` is tied 0, and ARMED waits indefinitely.

## Test plan
All scenarios use ADDR_W=4, PRE_DEPTH=4, AUTO_TIMEOUT=8.
- Rising trigger. Reset, trig_level=50, slope=0, samples 0,10,20,...
  - Required: 40 is written at adr 4 in ARMED.
  - 50 triggers at adr 5: trig_adr=5, start_adr=1.
  - 11 POST writes follow; `capture_done`=1 with the write to adr 0.
- Crossing during PRE_FILL. Samples 0,60,0,60,0,60.
  - Required: no trigger inside the first 4 writes.
  - Trigger on the 60 at adr 5: trig_adr=5.
- Falling trigger. slope=1, trig_level=100, samples 200,150,120,110,105,90.
  - Required: trigger at the 90 (adr 5), start_adr=1.
- Rearm. In DONE with wr_adr last=0, pulse `rearm` high 2 cycles.
  - Required: `capture_done` falls 3 cycles after the rise.
  - The next write lands at adr 1; rearm pulses during POST have no effect.
- Auto trigger. Macro defined, constant samples 0, trig_level=128.
  - Required: trigger on the 9th armed sample and `auto_fired`=1.
  - With the macro undefined, `capture_done` never rises over 1000 samples.
- Reset mid-POST. Assert `reset` 1 cycle during POST.
  - Required: all outputs return to their reset values, `state_dbg`=0, and capture restarts at adr 0.

Source files
------------

// File: rtl/capture_sequencer.sv
// Oscilloscope trigger/capture sequencer: circular sample writes, pre-trigger history, level/slope trigger.
// Optional auto trigger after AUTO_TIMEOUT untriggered armed samples: define CAPTURE_AUTO_TRIG_EN.
module capture_sequencer #(
  parameter int ADDR_W       = 12,
  parameter int PRE_DEPTH    = 1024,
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic              osc_clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [7:0]        sample,
  input  logic [7:0]        trig_level,
  input  logic              trig_slope,
  input  logic              rearm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_adr,
  output logic [7:0]        wr_data,
  output logic              capture_done,
  output logic [ADDR_W-1:0] trig_adr,
  output logic [ADDR_W-1:0] start_adr,
  output logic              auto_fired,
  output logic [1:0]        state_dbg
);

  // state    | meaning
  // PRE_FILL | writing pre-trigger history, trigger ignored
  // ARMED    | writing and watching for a trigger
  // POST     | writing the post-trigger segment
  // DONE     | record frozen, waiting for rearm
  typedef enum logic [1:0] {
    ST_PRE_FILL = 2'd0,
    ST_ARMED    = 2'd1,
    ST_POST     = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam int DEPTH    = 1 << ADDR_W;
  localparam int POST_LEN = DEPTH - PRE_DEPTH - 1;
  localparam state_t ST_START = (PRE_DEPTH == 0) ? ST_ARMED : ST_PRE_FILL;
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_DEPTH - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_LEN - 1);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_DEPTH);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [7:0]        r_prev;
  logic              r_prev_vld;
  logic              w_prev_clr;
  logic [2:0]        r_rearm_sync;
  logic              r_wr_en, r_done;
  logic [ADDR_W-1:0] r_wr_adr, r_trig_adr, r_start_adr;
  logic [7:0]        r_wr_data;
  logic              w_write, w_rearm_rise, w_trig_lvl, w_auto_hit, w_trig;

  assign w_write      = sample_valid && (r_state != ST_DONE);
  assign w_rearm_rise = r_rearm_sync[1] && !r_rearm_sync[2];
  assign w_trig_lvl   = r_prev_vld && (trig_slope
                        ? ((r_prev > trig_level) && (sample <= trig_level))
                        : ((r_prev < trig_level) && (sample >= trig_level)));
  assign w_trig       = w_write && (r_state == ST_ARMED) && (w_trig_lvl || w_auto_hit);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_prev_clr  = 1'b0;
    case (r_state)
      ST_PRE_FILL: if (w_write) begin
        if (r_cnt == PRE_LAST) begin
          w_state_nxt = ST_ARMED;
          w_cnt_nxt   = '0;
          w_prev_clr  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_ARMED: if (w_trig) begin
        w_cnt_nxt   = '0;
        w_state_nxt = (POST_LEN == 0) ? ST_DONE : ST_POST;
      end
      ST_POST: if (w_write) begin
        if (r_cnt == POST_LAST) w_state_nxt = ST_DONE;
        else                    w_cnt_nxt   = r_cnt + 1'b1;
      end
      ST_DONE: if (w_rearm_rise) begin
        w_state_nxt = ST_START;
        w_cnt_nxt   = '0;
        w_prev_clr  = 1'b1;
      end
      default: w_state_nxt = ST_START;
    endcase
  end

  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_START;
      r_cnt        <= '0;
      r_ptr        <= '0;
      r_prev       <= '0;
      r_prev_vld   <= 1'b0;
      r_rearm_sync <= '0;
      r_wr_en      <= 1'b0;
      r_wr_adr     <= '0;
      r_wr_data    <= '0;
      r_done       <= 1'b0;
      r_trig_adr   <= '0;
      r_start_adr  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rearm_sync <= {r_rearm_sync[1:0], rearm};
      r_wr_en      <= w_write;
      r_done       <= (w_state_nxt == ST_DONE);
      if (w_write) begin
        r_wr_adr  <= r_ptr;
        r_wr_data <= sample;
        r_ptr     <= r_ptr + 1'b1;
      end
      if (w_prev_clr) begin
        r_prev_vld <= 1'b0;
      end else if (w_write) begin
        r_prev     <= sample;
        r_prev_vld <= 1'b1;
      end
      if (w_trig) begin
        r_trig_adr  <= r_ptr;
        r_start_adr <= r_ptr - PRE_OFS;
      end
    end
  end

`ifdef CAPTURE_AUTO_TRIG_EN
  logic [15:0] r_auto_cnt;
  logic        r_auto_fired;

  assign w_auto_hit = (r_auto_cnt == 16'(AUTO_TIMEOUT));

  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      r_auto_cnt   <= '0;
      r_auto_fired <= 1'b0;
    end else begin
      if ((r_state != ST_ARMED) && (w_state_nxt == ST_ARMED))
        r_auto_cnt <= '0;
      else if ((r_state == ST_ARMED) && w_write && !w_trig)
        r_auto_cnt <= r_auto_cnt + 16'd1;
      if (w_trig && !w_trig_lvl)
        r_auto_fired <= 1'b1;
      else if ((r_state == ST_DONE) && w_rearm_rise)
        r_auto_fired <= 1'b0;
    end
  end

  assign auto_fired = r_auto_fired;
`else
  assign w_auto_hit = 1'b0;
  assign auto_fired = 1'b0 && (AUTO_TIMEOUT != 0);
`endif

  assign wr_en        = r_wr_en;
  assign wr_adr       = r_wr_adr;
  assign wr_data      = r_wr_data;
  assign capture_done = r_done;
  assign trig_adr     = r_trig_adr;
  assign start_adr    = r_start_adr;
  assign state_dbg    = r_state;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer with ADDR_W=4, PRE_DEPTH=4, AUTO_TIMEOUT=8.
module tb_capture_sequencer;

  logic       osc_clk = 1'b0;
  logic       reset;
  logic       sample_valid;
  logic [7:0] sample;
  logic [7:0] trig_level;
  logic       trig_slope;
  logic       rearm;
  logic       wr_en;
  logic [3:0] wr_adr;
  logic [7:0] wr_data;
  logic       capture_done;
  logic [3:0] trig_adr;
  logic [3:0] start_adr;
  logic       auto_fired;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  capture_sequencer #(.ADDR_W(4), .PRE_DEPTH(4), .AUTO_TIMEOUT(8)) dut (
    .osc_clk(osc_clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
    .trig_level(trig_level), .trig_slope(trig_slope), .rearm(rearm),
    .wr_en(wr_en), .wr_adr(wr_adr), .wr_data(wr_data), .capture_done(capture_done),
    .trig_adr(trig_adr), .start_adr(start_adr), .auto_fired(auto_fired), .state_dbg(state_dbg)
  );

  always #5 osc_clk = ~osc_clk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic send_sample(input logic [7:0] v);
    @(negedge osc_clk);
    sample_valid = 1'b1;
    sample       = v;
    @(negedge osc_clk);
    sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge osc_clk);
    reset = 1'b1;
    @(negedge osc_clk);
    @(negedge osc_clk);
    reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"},   wr_en, 0);
    check({tag, "_wr_adr"},  wr_adr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_done"},    capture_done, 0);
    check({tag, "_trig"},    trig_adr, 0);
    check({tag, "_start"},   start_adr, 0);
    check({tag, "_auto"},    auto_fired, 0);
    check({tag, "_state"},   state_dbg, 0);
  endtask

  initial begin
    reset = 1'b1; sample_valid = 1'b0; sample = 8'd0;
    trig_level = 8'd50; trig_slope = 1'b0; rearm = 1'b0;
    repeat (3) @(negedge osc_clk);
    check_reset_outputs("rst");
    reset = 1'b0;

    // rising trigger: 0,10,20,...
    for (int i = 0; i < 4; i++) begin
      send_sample(8'(10 * i));
      check("pre_adr", wr_adr, i);
      check("pre_data", wr_data, 10 * i);
      check("pre_state", state_dbg, (i == 3) ? 1 : 0);
    end
    check("pre_wren", wr_en, 1);
    @(negedge osc_clk);
    check("wren_1cyc", wr_en, 0);
    send_sample(8'd40);
    check("armed_adr", wr_adr, 4);
    check("armed_data", wr_data, 40);
    check("armed_state", state_dbg, 1);
    send_sample(8'd50);
    check("rise_state", state_dbg, 2);
    check("rise_trig", trig_adr, 5);
    check("rise_start", start_adr, 1);
    for (int i = 0; i < 11; i++) begin
      send_sample(8'(60 + 10 * i));
      check("post_adr", wr_adr, (6 + i) % 16);
      if (i == 9) check("post_done_lo", capture_done, 0);
    end
    check("done_hi", capture_done, 1);
    check("done_state", state_dbg, 3);
    send_sample(8'd7);
    check("done_nowrite", wr_en, 0);
    check("done_adr_hold", wr_adr, 0);

    // rearm: 2-cycle pulse, done falls on 3rd edge
    @(negedge osc_clk);
    rearm = 1'b1;
    @(negedge osc_clk);
    @(negedge osc_clk);
    rearm = 1'b0;
    check("rearm_2edges", capture_done, 1);
    @(negedge osc_clk);
    check("rearm_3edges", capture_done, 0);
    check("rearm_state", state_dbg, 0);
    send_sample(8'd0);
    check("rearm_next_adr", wr_adr, 1);

    // crossing during pre-fill
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_sample((i % 2) ? 8'd60 : 8'd0);
      check("cross_state", state_dbg, (i == 3) ? 1 : 0);
    end
    send_sample(8'd0);
    check("cross_armed", state_dbg, 1);
    send_sample(8'd60);
    check("cross_state_post", state_dbg, 2);
    check("cross_trig", trig_adr, 5);
    check("cross_start", start_adr, 1);
    @(negedge osc_clk);
    rearm = 1'b1;
    repeat (2) @(negedge osc_clk);
    rearm = 1'b0;
    repeat (4) @(negedge osc_clk);
    check("post_rearm_ignored", state_dbg, 2);
    for (int i = 0; i < 10; i++) send_sample(8'd60);
    check("cross_done_lo", capture_done, 0);
    send_sample(8'd60);
    check("cross_done_hi", capture_done, 1);
    repeat (5) @(negedge osc_clk);
    check("rearm_not_remembered", state_dbg, 3);

    // falling trigger, then reset mid-POST
    trig_slope = 1'b1; trig_level = 8'd100;
    do_reset();
    send_sample(8'd200); send_sample(8'd150); send_sample(8'd120);
    send_sample(8'd110); send_sample(8'd105);
    check("fall_armed", state_dbg, 1);
    send_sample(8'd90);
    check("fall_state", state_dbg, 2);
    check("fall_trig", trig_adr, 5);
    check("fall_start", start_adr, 1);
    send_sample(8'd80);
    send_sample(8'd70);
    check("fall_post_adr", wr_adr, 7);
    @(negedge osc_clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge osc_clk);
    reset = 1'b0;
    check_reset_outputs("midrst_rel");
    send_sample(8'd33);
    check("restart_adr", wr_adr, 0);
    check("restart_data", wr_data, 33);

    // auto trigger
    trig_slope = 1'b0; trig_level = 8'd128;
    do_reset();
    for (int i = 0; i < 4; i++) send_sample(8'd0);
`ifdef CAPTURE_AUTO_TRIG_EN
    for (int i = 0; i < 8; i++) send_sample(8'd0);
    check("auto_wait_state", state_dbg, 1);
    check("auto_wait_flag", auto_fired, 0);
    send_sample(8'd0);
    check("auto_state", state_dbg, 2);
    check("auto_flag", auto_fired, 1);
    check("auto_trig", trig_adr, 12);
    check("auto_start", start_adr, 8);
`else
    for (int i = 0; i < 1000; i++) send_sample(8'd0);
    check("noauto_done", capture_done, 0);
    check("noauto_state", state_dbg, 1);
    check("noauto_flag", auto_fired, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
